// File: rtl/pll_lock_sequencer_if.sv
// PLL sequencer signal bundle.
// master : the sequencer (samples pll_lock/clken, drives everything else)
// slave  : the PLL / datapath side
//   pll_lock   raw PLL lock, asynchronous to the reference clock
//   clken      requested datapath clock enable
//   pll_rst    reset request to the PLL, active high
//   sys_rst    downstream datapath reset, active high
//   clken_out  qualified datapath clock enable
//   locked     high only while running
//   fail       sticky failure flag
//   lost_cnt   saturating count of lock-loss events while running
//   state      current sequencer state encoding
interface pll_lock_sequencer_if;
   logic       pll_lock;
   logic       clken;
   logic       pll_rst;
   logic       sys_rst;
   logic       clken_out;
   logic       locked;
   logic       fail;
   logic [3:0] lost_cnt;
   logic [2:0] state;

   modport master (
      input  pll_lock, clken,
      output pll_rst, sys_rst, clken_out, locked, fail, lost_cnt, state
   );

   modport slave (
      output pll_lock, clken,
      input  pll_rst, sys_rst, clken_out, locked, fail, lost_cnt, state
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer, running on the PLL reference clock.
// Holds the PLL in reset, qualifies a synchronized lock for LOCK_STABLE
// consecutive cycles, then releases the datapath reset and clock enable.
// A lost lock sends the sequencer back to lock qualification; an attempt
// that does not reach RUN within TIMEOUT cycles re-pulses the PLL reset,
// and MAX_RETRY failed attempts end in a sticky FAIL.
// Ports:
//   clk  reference clock (rising edge)
//   rst  asynchronous active-low reset
//   bus  pll_lock_sequencer_if.master (see interface for signal list)
//
// state     | meaning
// ----------+---------------------------------------------------------
// RESET_PLL | pll_rst high for RST_PULSE cycles
// WAIT_LOCK | waiting for synchronized lock, attempt timer running
// STABLE    | counting consecutive lock cycles, attempt timer running
// RUN       | datapath released, watching for lock loss
// FAIL      | retries exhausted, held until rst
module pll_lock_sequencer #(
   parameter int unsigned RST_PULSE   = 8,
   parameter int unsigned LOCK_STABLE = 16,
   parameter int unsigned TIMEOUT     = 256,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   pll_lock_sequencer_if.master  bus
);

   localparam int unsigned PW = $clog2(RST_PULSE);
   localparam int unsigned SW = $clog2(LOCK_STABLE);
   localparam int unsigned TW = $clog2(TIMEOUT);

   // Down-counter loads; each terminal count is zero.
   localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE - 1);
   // WAIT_LOCK->STABLE already accounts for the first lock cycle.
   localparam logic [SW-1:0] STAB_LOAD  = SW'(LOCK_STABLE - 2);
   localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT - 1);
   localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RESET_PLL = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          sync1_q, lock_s_q;
   logic [PW-1:0] pulse_q, pulse_d;
   logic [SW-1:0] stab_q, stab_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [3:0]    retry_q, retry_d;
   logic [3:0]    lost_q, lost_d;
   logic          attempt_fail;

   logic          pll_rst_q, sys_rst_q, clken_out_q, locked_q, fail_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= bus.pll_lock;
         lock_s_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_RESET_PLL;
         pulse_q     <= PULSE_LOAD;
         stab_q      <= '0;
         tmo_q       <= TMO_LOAD;
         retry_q     <= '0;
         lost_q      <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         clken_out_q <= 1'b0;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pulse_q     <= pulse_d;
         stab_q      <= stab_d;
         tmo_q       <= tmo_d;
         retry_q     <= retry_d;
         lost_q      <= lost_d;
         // Outputs decode the next state so they change on the entering edge.
         pll_rst_q   <= (state_d == S_RESET_PLL);
         sys_rst_q   <= (state_d != S_RUN);
         clken_out_q <= (state_d == S_RUN) && bus.clken;
         locked_q    <= (state_d == S_RUN);
         fail_q      <= (state_d == S_FAIL);
      end
   end

   always_comb begin
      state_d      = state_q;
      pulse_d      = pulse_q;
      stab_d       = stab_q;
      tmo_d        = tmo_q;
      retry_d      = retry_q;
      lost_d       = lost_q;
      attempt_fail = 1'b0;

      case (state_q)
         S_RESET_PLL: begin
            if (pulse_q == '0) begin
               state_d = S_WAIT_LOCK;
               tmo_d   = TMO_LOAD;
            end else begin
               pulse_d = pulse_q - PW'(1);
            end
         end

         S_WAIT_LOCK: begin
            if (tmo_q == '0) begin
               attempt_fail = 1'b1;
            end else begin
               tmo_d = tmo_q - TW'(1);
               if (lock_s_q) begin
                  state_d = S_STABLE;
                  stab_d  = STAB_LOAD;
               end
            end
         end

         S_STABLE: begin
            // Qualification completing on the timeout cycle still wins.
            if (lock_s_q && (stab_q == '0)) begin
               state_d = S_RUN;
               retry_d = '0;
            end else if (tmo_q == '0) begin
               attempt_fail = 1'b1;
            end else begin
               tmo_d = tmo_q - TW'(1);
               if (lock_s_q) begin
                  stab_d = stab_q - SW'(1);
               end else begin
                  state_d = S_WAIT_LOCK;
               end
            end
         end

         S_RUN: begin
            if (!lock_s_q) begin
               state_d = S_WAIT_LOCK;
               tmo_d   = TMO_LOAD;
               if (lost_q != 4'hF) begin
                  lost_d = lost_q + 4'd1;
               end
            end
         end

         S_FAIL: begin
         end

         default: begin
            state_d = S_RESET_PLL;
            pulse_d = PULSE_LOAD;
         end
      endcase

      if (attempt_fail) begin
         retry_d = retry_q + 4'd1;
         if (retry_d == RETRY_MAX) begin
            state_d = S_FAIL;
         end else begin
            state_d = S_RESET_PLL;
            pulse_d = PULSE_LOAD;
         end
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.sys_rst   = sys_rst_q;
   assign bus.clken_out = clken_out_q;
   assign bus.locked    = locked_q;
   assign bus.fail      = fail_q;
   assign bus.lost_cnt  = lost_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
module tb_pll_lock_sequencer;

   localparam int RST_PULSE   = 8;
   localparam int LOCK_STABLE = 16;
   localparam int TIMEOUT     = 256;
   localparam int MAX_RETRY   = 3;

   logic clk;
   logic rst;

   pll_lock_sequencer_if bus_if ();

   pll_lock_sequencer #(
      .RST_PULSE   (RST_PULSE),
      .LOCK_STABLE (LOCK_STABLE),
      .TIMEOUT     (TIMEOUT),
      .MAX_RETRY   (MAX_RETRY)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: counts up exactly as the behaviour is described.
   int m_st, m_pulse, m_stab, m_tmo, m_retry, m_lost;
   bit m_clko;
   bit m_hist[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      m_st = 0; m_pulse = 0; m_stab = 0; m_tmo = 0; m_retry = 0; m_lost = 0;
      m_clko = 1'b0;
      m_hist = {1'b0, 1'b0};
   endfunction

   function automatic void attempt_failed();
      m_retry++;
      if (m_retry == MAX_RETRY) m_st = 4;
      else begin
         m_st = 0;
         m_pulse = 0;
      end
   endfunction

   function automatic void model_step();
      bit ls;
      ls = m_hist[0];
      void'(m_hist.pop_front());
      m_hist.push_back(bus_if.pll_lock);
      case (m_st)
         0: if (m_pulse == RST_PULSE - 1) begin m_st = 1; m_tmo = 0; end
            else m_pulse++;
         1: if (m_tmo == TIMEOUT - 1) attempt_failed();
            else begin
               if (ls) begin m_st = 2; m_stab = 1; end
               m_tmo++;
            end
         2: if (ls && m_stab + 1 == LOCK_STABLE) begin m_st = 3; m_retry = 0; end
            else if (m_tmo == TIMEOUT - 1) attempt_failed();
            else begin
               if (ls) m_stab++;
               else begin m_st = 1; m_stab = 0; end
               m_tmo++;
            end
         3: if (!ls) begin
               m_st = 1; m_tmo = 0;
               if (m_lost < 15) m_lost++;
            end
         default: ;
      endcase
      m_clko = (m_st == 3) && bus_if.clken;
   endfunction

   function automatic logic [11:0] dut_vec();
      return {bus_if.state, bus_if.pll_rst, bus_if.sys_rst, bus_if.clken_out,
              bus_if.locked, bus_if.fail, bus_if.lost_cnt};
   endfunction

   function automatic logic [11:0] model_vec();
      logic [2:0] s;
      logic [3:0] l;
      s = 3'(m_st);
      l = 4'(m_lost);
      return {s, m_st == 0, m_st != 3, m_clko, m_st == 3, m_st == 4, l};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check("cycle_outputs", 32'(dut_vec()), 32'(model_vec()));
   endtask

   // Called at a falling edge; asserts rst mid-phase, checks outputs
   // immediately, then releases at the next falling edge.
   task automatic do_reset();
      logic [11:0] rst_vec;
      rst_vec = {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
      #2 rst = 1'b0;
      model_reset();
      #1 check("async_reset_values", 32'(dut_vec()), 32'(rst_vec));
      @(negedge clk);
      rst = 1'b1;
      cyc = 0;
   endtask

   task automatic wait_locked(input int budget, input string nm);
      int n;
      n = 0;
      while (bus_if.locked !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check(nm, 32'(bus_if.locked), 32'd1);
   endtask

   task automatic pulse_len(input string nm);
      int n;
      n = 0;
      while (bus_if.pll_rst === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check(nm, n, RST_PULSE);
   endtask

   typedef struct {
      string name;
      int    lock_at;     // pll_lock rises after this edge (-1: never)
      bit    glitch;      // one-cycle drop 10 cycles after the rise
      int    run_len;
      int    exp_lock;    // edge at which locked first rises (0: never)
      int    exp_pulses;  // extra pll_rst pulses after the first
      int    exp_fail;    // edge at which fail rises (0: never)
   } vec_t;

   vec_t vecs[6];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, actual running required finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_lock, pulses, first_fail;
      bit prev_rst;

      vecs[0] = '{"clean_lock",     20, 1'b0,  60, 20 + 2 + 16, 0, 0};
      vecs[1] = '{"glitchy_lock",   20, 1'b1,  70, 31 + 2 + 16, 0, 0};
      vecs[2] = '{"lock_in_reset",   5, 1'b0,  40, 24,          0, 0};
      vecs[3] = '{"collision",     246, 1'b0, 300, 264,         0, 0};
      vecs[4] = '{"late_by_one",   247, 1'b0, 320, 288,         1, 0};
      vecs[5] = '{"no_lock",        -1, 1'b0, 900, 0,           2, 3 * (RST_PULSE + TIMEOUT)};

      rst = 1'b0;
      bus_if.pll_lock = 1'b0;
      bus_if.clken    = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      for (int v = 0; v < 6; v++) begin
         bus_if.pll_lock = 1'b0;
         bus_if.clken    = 1'b1;
         do_reset();
         first_lock = 0; pulses = 0; first_fail = 0; prev_rst = 1'b1;
         for (int c = 1; c <= vecs[v].run_len; c++) begin
            bus_if.pll_lock = (vecs[v].lock_at >= 0) && (cyc >= vecs[v].lock_at) &&
                              !(vecs[v].glitch && cyc == vecs[v].lock_at + 10);
            tick();
            if (bus_if.locked === 1'b1 && first_lock == 0) first_lock = cyc;
            if (bus_if.pll_rst === 1'b1 && !prev_rst) pulses++;
            prev_rst = bus_if.pll_rst;
            if (bus_if.fail === 1'b1 && first_fail == 0) first_fail = cyc;
         end
         check({vecs[v].name, "_lock_edge"}, first_lock, vecs[v].exp_lock);
         check({vecs[v].name, "_pulses"},    pulses,     vecs[v].exp_pulses);
         check({vecs[v].name, "_fail_edge"}, first_fail, vecs[v].exp_fail);
      end

      // Still in FAIL: a late lock is ignored.
      bus_if.pll_lock = 1'b1;
      repeat (40) tick();
      check("fail_state_held", 32'(bus_if.state), 32'd4);
      check("fail_flag_held",  32'(bus_if.fail),  32'd1);
      check("fail_pll_rst_low", 32'(bus_if.pll_rst), 32'd0);

      // Reset out of FAIL restarts with a full pll_rst pulse.
      do_reset();
      bus_if.pll_lock = 1'b0;
      pulse_len("pulse_after_fail_reset");

      // Lock loss while running.
      bus_if.pll_lock = 1'b1;
      wait_locked(60, "first_run");
      bus_if.clken = 1'b0;
      tick();
      check("clken_out_low", 32'(bus_if.clken_out), 32'd0);
      bus_if.clken = 1'b1;
      tick();
      check("clken_out_high", 32'(bus_if.clken_out), 32'd1);
      for (int k = 1; k <= 17; k++) begin
         bus_if.pll_lock = 1'b0;
         tick(); tick();
         check("loss_still_locked_2", 32'(bus_if.locked), 32'd1);
         tick();
         check("loss_sys_rst_3",   32'(bus_if.sys_rst),   32'd1);
         check("loss_clken_out_3", 32'(bus_if.clken_out), 32'd0);
         tick(); tick();
         bus_if.pll_lock = 1'b1;
         wait_locked(40, "relock");
         check("lost_cnt", 32'(bus_if.lost_cnt), (k > 15) ? 32'd15 : 32'(k));
      end

      // Reset mid-STABLE clears lost_cnt and restarts.
      bus_if.pll_lock = 1'b0;
      repeat (3) tick();
      bus_if.pll_lock = 1'b1;
      begin
         int n;
         n = 0;
         while (bus_if.state !== 3'd2 && n < 20) begin
            tick();
            n++;
         end
      end
      check("reach_stable", 32'(bus_if.state), 32'd2);
      repeat (3) tick();
      do_reset();
      pulse_len("pulse_after_stable_reset");

      // Randomized segments against the reference model.
      for (int seg = 0; seg < 8; seg++) begin
         int mode;
         mode = $urandom_range(0, 3);
         if (seg[0]) do_reset();
         for (int i = 0; i < 900; i++) begin
            case (mode)
               0: bus_if.pll_lock = 1'b0;
               1: if ($urandom_range(0, 59) == 0) bus_if.pll_lock = ~bus_if.pll_lock;
               2: if ($urandom_range(0, 7) == 0)  bus_if.pll_lock = ~bus_if.pll_lock;
               default: bus_if.pll_lock = ($urandom_range(0, 199) != 0);
            endcase
            bus_if.clken = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2999) == 0) do_reset();
            tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
